// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port shared by the loader and its neighbours.
// The master side produces the stream and observes the memory writes; the slave side is the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: turns a framed byte stream (count, big-endian words, XOR checksum)
// into sequential word writes while holding the core off via busy.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          error
);
    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        CSUM
    } state_t;

    localparam logic [16:0]       MAX_LIMIT = 17'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            next_state;
    logic [15:0]       count;
    logic [15:0]       word_cnt;
    logic [1:0]        byte_cnt;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              ready;
    logic              we;
    logic              xfer;
    logic [15:0]       hdr_count;
    logic              count_over;
    logic              last_word;

    assign bus.byte_ready = ready;
    assign bus.mem_we     = we;
    assign bus.mem_waddr  = waddr;
    assign bus.mem_wdata  = wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Handshake and status outputs depend on state alone, so async reset clears them at once.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        we         = 1'b0;
        busy       = (state != IDLE);
        hdr_count  = {count[15:8], bus.byte_data};
        count_over = ({1'b0, hdr_count} > MAX_LIMIT);
        last_word  = ((word_cnt + 16'd1) == count);
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = HDR_HI;
            end
            HDR_HI: begin
                ready = 1'b1;
                xfer  = bus.byte_valid;
                if (xfer) next_state = HDR_LO;
            end
            HDR_LO: begin
                ready = 1'b1;
                xfer  = bus.byte_valid;
                if (xfer) begin
                    if (count_over)               next_state = IDLE;
                    else if (hdr_count == 16'd0)  next_state = CSUM;
                    else                          next_state = DATA;
                end
            end
            DATA: begin
                ready = 1'b1;
                xfer  = bus.byte_valid;
                if (xfer && byte_cnt == 2'd3) next_state = WRITE;
            end
            WRITE: begin
                we         = 1'b1;
                next_state = last_word ? CSUM : DATA;
            end
            CSUM: begin
                ready = 1'b1;
                xfer  = bus.byte_valid;
                if (xfer) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: header latch, word assembly MSB first, running XOR, and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            csum     <= '0;
            waddr    <= '0;
            wdata    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        error    <= 1'b0;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                        waddr    <= '0;
                    end
                end
                HDR_HI: begin
                    if (xfer) count[15:8] <= bus.byte_data;
                end
                HDR_LO: begin
                    if (xfer) begin
                        count[7:0] <= bus.byte_data;
                        if (count_over) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        wdata    <= {wdata[23:0], bus.byte_data};
                        csum     <= csum ^ bus.byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    waddr    <= waddr + ADDR_ONE;
                    word_cnt <= word_cnt + 16'd1;
                end
                CSUM: begin
                    if (xfer) begin
                        if (bus.byte_data != csum) error <= 1'b1;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: streams hand-built frames and checks writes and status.
module tb_imem_loader;
    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
    logic error;

    int tests;
    int failed;
    int wrCount;
    logic [31:0] wrAddr [0:7];
    logic [31:0] wrData [0:7];
    bit weReadyOverlap;
    int totalWaits;
    int stallWaits;
    int w;

    imem_loader_if #(.ADDR_W(10)) bus ();

    imem_loader #(
        .ADDR_W(10),
        .MAX_WORDS(1024)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bus(bus.slave),
        .busy(busy),
        .done(done),
        .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every write pulse away from the active edge.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (wrCount < 8) begin
                wrAddr[wrCount] = {22'b0, bus.mem_waddr};
                wrData[wrCount] = bus.mem_wdata;
            end
            wrCount++;
            if (bus.byte_ready) weReadyOverlap = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idleCycles(input int n);
        bus.byte_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Present one byte and hold it until it is accepted; waits counts cycles with ready low.
    task automatic applyStimulus(input logic [7:0] b, output int waits);
        bit accepted;
        accepted = 1'b0;
        waits = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data = b;
        while (!accepted && waits < 20) begin
            @(negedge clk);
            if (bus.byte_ready) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!accepted) checkOutput("xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic sendFrame(input logic [7:0] csumByte, input bit gaps,
                             output int tw, output int sw);
        logic [7:0] frame [0:10];
        int wt;
        frame[0] = 8'h00; frame[1] = 8'h02;
        frame[2] = 8'h20; frame[3] = 8'h24; frame[4] = 8'h00; frame[5] = 8'h0A;
        frame[6] = 8'h00; frame[7] = 8'h22; frame[8] = 8'h18; frame[9] = 8'h20;
        frame[10] = csumByte;
        tw = 0;
        sw = -1;
        wrCount = 0;
        weReadyOverlap = 1'b0;
        pulseStart();
        for (int i = 0; i < 11; i++) begin
            if (i == 10) begin
                checkOutput("busy_before_csum", {31'b0, busy}, 32'd1);
                checkOutput("done_before_csum", {31'b0, done}, 32'd0);
            end
            applyStimulus(frame[i], wt);
            tw += wt;
            if (i == 6) sw = wt;
            if (gaps && i != 5 && i != 10) idleCycles(1);
        end
        bus.byte_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        wrCount = 0;
        weReadyOverlap = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_error", {31'b0, error}, 32'd0);
        checkOutput("rst_ready", {31'b0, bus.byte_ready}, 32'd0);
        checkOutput("rst_we", {31'b0, bus.mem_we}, 32'd0);
        checkOutput("rst_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;
        idleCycles(1);

        // Scenario 1: back-to-back stream
        sendFrame(8'h14, 1'b0, totalWaits, stallWaits);
        checkOutput("s1_busy", {31'b0, busy}, 32'd0);
        checkOutput("s1_done", {31'b0, done}, 32'd1);
        checkOutput("s1_error", {31'b0, error}, 32'd0);
        idleCycles(2);
        checkOutput("s1_wr_count", wrCount, 32'd2);
        checkOutput("s1_addr0", wrAddr[0], 32'd0);
        checkOutput("s1_data0", wrData[0], 32'h2024000A);
        checkOutput("s1_addr1", wrAddr[1], 32'd1);
        checkOutput("s1_data1", wrData[1], 32'h00221820);
        checkOutput("s1_stall_cycles", totalWaits, 32'd2);
        checkOutput("s1_we_with_ready", {31'b0, weReadyOverlap}, 32'd0);

        // Scenario 2: gapped stream, byte presented during WRITE waits one cycle
        sendFrame(8'h14, 1'b1, totalWaits, stallWaits);
        checkOutput("s2_done", {31'b0, done}, 32'd1);
        checkOutput("s2_error", {31'b0, error}, 32'd0);
        idleCycles(2);
        checkOutput("s2_wr_count", wrCount, 32'd2);
        checkOutput("s2_data0", wrData[0], 32'h2024000A);
        checkOutput("s2_addr1", wrAddr[1], 32'd1);
        checkOutput("s2_data1", wrData[1], 32'h00221820);
        checkOutput("s2_write_stall", stallWaits, 32'd1);
        checkOutput("s2_we_with_ready", {31'b0, weReadyOverlap}, 32'd0);

        // Scenario 3: bad checksum still writes both words
        sendFrame(8'h15, 1'b0, totalWaits, stallWaits);
        checkOutput("s3_done", {31'b0, done}, 32'd1);
        checkOutput("s3_error", {31'b0, error}, 32'd1);
        idleCycles(2);
        checkOutput("s3_wr_count", wrCount, 32'd2);
        checkOutput("s3_data1", wrData[1], 32'h00221820);

        // Scenario 4: count 1025 overflows
        wrCount = 0;
        pulseStart();
        checkOutput("s4_error_cleared", {31'b0, error}, 32'd0);
        applyStimulus(8'h04, w);
        applyStimulus(8'h01, w);
        checkOutput("s4_done", {31'b0, done}, 32'd1);
        checkOutput("s4_error", {31'b0, error}, 32'd1);
        checkOutput("s4_busy", {31'b0, busy}, 32'd0);
        checkOutput("s4_ready", {31'b0, bus.byte_ready}, 32'd0);
        idleCycles(3);
        checkOutput("s4_ready_later", {31'b0, bus.byte_ready}, 32'd0);
        checkOutput("s4_wr_count", wrCount, 32'd0);

        // Scenario 5: restart clears sticky status, then async reset mid-word
        wrCount = 0;
        pulseStart();
        checkOutput("s5_done_cleared", {31'b0, done}, 32'd0);
        checkOutput("s5_error_cleared", {31'b0, error}, 32'd0);
        checkOutput("s5_busy", {31'b0, busy}, 32'd1);
        applyStimulus(8'h00, w);
        applyStimulus(8'h02, w);
        applyStimulus(8'h20, w);
        applyStimulus(8'h24, w);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("s5_rst_ready", {31'b0, bus.byte_ready}, 32'd0);
        checkOutput("s5_rst_we", {31'b0, bus.mem_we}, 32'd0);
        checkOutput("s5_rst_waddr", {22'b0, bus.mem_waddr}, 32'd0);
        checkOutput("s5_rst_wdata", bus.mem_wdata, 32'd0);
        checkOutput("s5_rst_done", {31'b0, done}, 32'd0);
        bus.byte_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(1);
        sendFrame(8'h14, 1'b0, totalWaits, stallWaits);
        checkOutput("s5_done", {31'b0, done}, 32'd1);
        checkOutput("s5_error", {31'b0, error}, 32'd0);
        idleCycles(2);
        checkOutput("s5_wr_count", wrCount, 32'd2);
        checkOutput("s5_addr0", wrAddr[0], 32'd0);
        checkOutput("s5_data0", wrData[0], 32'h2024000A);
        checkOutput("s5_data1", wrData[1], 32'h00221820);

        // Scenario 6: empty frame with an ignored mid-frame start
        wrCount = 0;
        pulseStart();
        applyStimulus(8'h00, w);
        bus.byte_valid = 1'b0;
        pulseStart();
        applyStimulus(8'h00, w);
        applyStimulus(8'h00, w);
        checkOutput("s6_done", {31'b0, done}, 32'd1);
        checkOutput("s6_error", {31'b0, error}, 32'd0);
        checkOutput("s6_busy", {31'b0, busy}, 32'd0);
        idleCycles(2);
        checkOutput("s6_wr_count", wrCount, 32'd0);
        pulseStart();
        checkOutput("s6_restart_done", {31'b0, done}, 32'd0);
        checkOutput("s6_restart_busy", {31'b0, busy}, 32'd1);
        applyStimulus(8'h00, w);
        applyStimulus(8'h00, w);
        applyStimulus(8'h00, w);
        checkOutput("s6_final_done", {31'b0, done}, 32'd1);
        idleCycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
